// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_condlogic.sv
// Condition flags, condition evaluation and write gating for the multicycle controller.
module mc_condlogic
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       next_pc_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       cond_ex_d;
    logic       cond_ex_q;
    logic       n, z, c, v;

    assign {n, z} = nz_q;
    assign {c, v} = cv_q;

    always_comb begin
        cond_ex_d = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_d = z;
            COND_NE: cond_ex_d = ~z;
            COND_CS: cond_ex_d = c;
            COND_CC: cond_ex_d = ~c;
            COND_MI: cond_ex_d = n;
            COND_PL: cond_ex_d = ~n;
            COND_VS: cond_ex_d = v;
            COND_VC: cond_ex_d = ~v;
            COND_HI: cond_ex_d = c & ~z;
            COND_LS: cond_ex_d = ~(c & ~z);
            COND_GE: cond_ex_d = (n == v);
            COND_LT: cond_ex_d = (n != v);
            COND_GT: cond_ex_d = ~z & (n == v);
            COND_LE: cond_ex_d = ~(~z & (n == v));
            COND_AL: cond_ex_d = 1'b1;
            COND_NV: cond_ex_d = 1'b0;
            default: cond_ex_d = 1'b0;
        endcase
    end

    // flag_w_i is only non-zero in the execute states, so no state gating is needed here
    always_ff @(posedge clk) begin
        if (reset_i) begin
            nz_q      <= 2'b00;
            cv_q      <= 2'b00;
            cond_ex_q <= 1'b0;
        end else begin
            if (flag_w_i[1] && cond_ex_d) begin
                nz_q <= alu_flags_i[3:2];
            end
            if (flag_w_i[0] && cond_ex_d) begin
                cv_q <= alu_flags_i[1:0];
            end
            cond_ex_q <= cond_ex_d;
        end
    end

    // Delayed condition keeps an instruction's own flag update from cancelling its writeback
    assign pc_write_o  = ~reset_i & (next_pc_i | (pcs_i & cond_ex_q));
    assign reg_write_o = ~reset_i & reg_w_i & cond_ex_q;
    assign mem_write_o = ~reset_i & mem_w_i & cond_ex_q;

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM datapath with ALU decode and conditional write gating.
module multicycle_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [1:0]  RegSrc
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_cmd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign alu_cmd   = funct[4:1];
    assign unused_rn = ^Instr[7:4];

    state_t state_q, state_d, out_state;

    logic       next_pc, branch, reg_w, mem_w, alu_op, ir_write_s, pcs;
    logic [1:0] flag_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held, outputs show the FETCH pattern with every write suppressed
    assign out_state = reset ? S_FETCH : state_q;

    always_comb begin
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        alu_op     = 1'b0;
        ir_write_s = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WD;
        case (out_state)
            S_FETCH: begin
                ir_write_s = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                next_pc    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: begin
                alu_op = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Unrecognised commands fall back to ADD and never touch the flags
    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (alu_cmd)
                CMD_ADD: begin
                    ALUControl = ALU_ADD;
                    flag_w     = {funct[0], funct[0]};
                end
                CMD_SUB: begin
                    ALUControl = ALU_SUB;
                    flag_w     = {funct[0], funct[0]};
                end
                CMD_AND: begin
                    ALUControl = ALU_AND;
                    flag_w     = {funct[0], 1'b0};
                end
                CMD_ORR: begin
                    ALUControl = ALU_ORR;
                    flag_w     = {funct[0], 1'b0};
                end
                default: begin
                    ALUControl = ALU_ADD;
                    flag_w     = 2'b00;
                end
            endcase
        end
    end

    assign pcs     = branch | (reg_w & (rd == 4'hF));
    assign IRWrite = ir_write_s & ~reset;
    assign ImmSrc  = op;
    assign RegSrc  = {(op == OP_MEM), (op == OP_BR)};

    mc_condlogic u_condlogic (
        .clk         (clk),
        .reset_i     (reset),
        .cond_i      (cond),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (flag_w),
        .pcs_i       (pcs),
        .next_pc_i   (next_pc),
        .reg_w_i     (reg_w),
        .mem_w_i     (mem_w),
        .pc_write_o  (PCWrite),
        .reg_write_o (RegWrite),
        .mem_write_o (MemWrite)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle comparison against a phase-level model plus literal checkpoints.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic f_cond(input logic [3:0] cd, input logic [3:0] fl);
        logic nn, zz, cc, vv;
        {nn, zz, cc, vv} = fl;
        case (cd)
            0:  return zz;
            1:  return !zz;
            2:  return cc;
            3:  return !cc;
            4:  return nn;
            5:  return !nn;
            6:  return vv;
            7:  return !vv;
            8:  return cc && !zz;
            9:  return !cc || zz;
            10: return nn == vv;
            11: return nn != vv;
            12: return !zz && (nn == vv);
            13: return zz || (nn != vv);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic string f_next(input string ph, input logic [19:0] ins);
        logic [1:0] opx;
        opx = ins[15:14];
        if (ph == "FETCH") return "DECODE";
        if (ph == "DECODE") begin
            if (opx == 2'd1) return "MEMADR";
            if (opx == 2'd2) return "BRANCH";
            if (opx == 2'd3) return "FETCH";
            return ins[13] ? "EXECUTEI" : "EXECUTER";
        end
        if (ph == "MEMADR") return ins[8] ? "MEMREAD" : "MEMWRITE";
        if (ph == "MEMREAD") return "MEMWB";
        if (ph == "EXECUTER" || ph == "EXECUTEI") return "ALUWB";
        return "FETCH";
    endfunction

    function automatic logic [3:0] f_flags(input string ph, input logic [19:0] ins,
                                           input logic [3:0] fl, input logic [3:0] af);
        logic [3:0] r;
        int cmd;
        r   = fl;
        cmd = int'(ins[12:9]);
        if ((ph == "EXECUTER" || ph == "EXECUTEI") && ins[8] && f_cond(ins[19:16], fl)) begin
            if (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12) r[3:2] = af[3:2];
            if (cmd == 4 || cmd == 2) r[1:0] = af[1:0];
        end
        return r;
    endfunction

    function automatic logic [1:0] f_aluc(input int cmd);
        if (cmd == 2) return 2'd1;
        if (cmd == 0) return 2'd2;
        if (cmd == 12) return 2'd3;
        return 2'd0;
    endfunction

    string      m_phase = "FETCH";
    logic [3:0] m_flags = 4'h0;
    logic       m_condexd = 1'b0;
    logic       model_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase   <= "FETCH";
            m_flags   <= 4'h0;
            m_condexd <= 1'b0;
            model_on  <= 1'b1;
        end else if (model_on) begin
            m_flags   <= f_flags(m_phase, Instr, m_flags, ALUFlags);
            m_condexd <= f_cond(Instr[19:16], m_flags);
            m_phase   <= f_next(m_phase, Instr);
        end
    end

    string      ph;
    logic       e_regw, e_memw, e_pcs;
    logic [1:0] e_res, e_srcb, e_aluc;

    always @(negedge clk) begin
        if (model_on) begin
            ph     = reset ? "FETCH" : m_phase;
            e_regw = (ph == "MEMWB" || ph == "ALUWB");
            e_memw = (ph == "MEMWRITE");
            e_pcs  = (ph == "BRANCH") || (e_regw && Instr[3:0] == 4'hF);
            if (ph == "FETCH" || ph == "DECODE" || ph == "BRANCH") e_res = 2'd2;
            else if (ph == "MEMWB") e_res = 2'd1;
            else e_res = 2'd0;
            if (ph == "FETCH" || ph == "DECODE") e_srcb = 2'd2;
            else if (ph == "MEMADR" || ph == "EXECUTEI" || ph == "BRANCH") e_srcb = 2'd1;
            else e_srcb = 2'd0;
            e_aluc = (ph == "EXECUTER" || ph == "EXECUTEI") ? f_aluc(int'(Instr[12:9])) : 2'd0;
            chk({"PCWrite@", ph}, {3'b0, PCWrite},
                {3'b0, !reset && (ph == "FETCH" || (e_pcs && m_condexd))});
            chk({"RegWrite@", ph}, {3'b0, RegWrite}, {3'b0, !reset && e_regw && m_condexd});
            chk({"MemWrite@", ph}, {3'b0, MemWrite}, {3'b0, !reset && e_memw && m_condexd});
            chk({"IRWrite@", ph}, {3'b0, IRWrite}, {3'b0, !reset && ph == "FETCH"});
            chk({"AdrSrc@", ph}, {3'b0, AdrSrc}, {3'b0, ph == "MEMREAD" || ph == "MEMWRITE"});
            chk({"ALUSrcA@", ph}, {3'b0, ALUSrcA}, {3'b0, ph == "FETCH" || ph == "DECODE"});
            chk({"ResultSrc@", ph}, {2'b0, ResultSrc}, {2'b0, e_res});
            chk({"ALUSrcB@", ph}, {2'b0, ALUSrcB}, {2'b0, e_srcb});
            chk({"ALUControl@", ph}, {2'b0, ALUControl}, {2'b0, e_aluc});
            chk({"ImmSrc@", ph}, {2'b0, ImmSrc}, {2'b0, Instr[15:14]});
            chk({"RegSrc@", ph}, {2'b0, RegSrc}, {2'b0, Instr[15:14] == 2'd1, Instr[15:14] == 2'd2});
        end
    end

    // ---------------- directed stimulus ----------------
    logic       s_pcw  [0:7];
    logic       s_rw   [0:7];
    logic       s_mw   [0:7];
    logic       s_adr  [0:7];
    logic [1:0] s_res  [0:7];
    logic [1:0] s_aluc [0:7];
    logic [1:0] s_srcb [0:7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at the start of a FETCH cycle; snapshots outputs of each of the n cycles
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] fl, input int n);
        Instr    = ins;
        ALUFlags = fl;
        for (int k = 0; k < n; k++) begin
            #1;
            s_pcw[k]  = PCWrite;
            s_rw[k]   = RegWrite;
            s_mw[k]   = MemWrite;
            s_adr[k]  = AdrSrc;
            s_res[k]  = ResultSrc;
            s_aluc[k] = ALUControl;
            s_srcb[k] = ALUSrcB;
            tick();
        end
        $display("instr %05h flags=%h cycles=%0d pcw=%b%b%b%b%b rw=%b%b%b%b%b mw=%b%b%b%b%b", ins, fl, n,
                 s_pcw[0], s_pcw[1], s_pcw[2], s_pcw[3], s_pcw[4],
                 s_rw[0], s_rw[1], s_rw[2], s_rw[3], s_rw[4],
                 s_mw[0], s_mw[1], s_mw[2], s_mw[3], s_mw[4]);
    endtask

    localparam logic [19:0] I_ADD    = 20'hE0811;
    localparam logic [19:0] I_LDR    = 20'hE5912;
    localparam logic [19:0] I_SUBS   = 20'hE0512;
    localparam logic [19:0] I_STREQ  = 20'h05812;
    localparam logic [19:0] I_BEQ    = 20'h0A000;
    localparam logic [19:0] I_ADDEQS = 20'h00911;
    localparam logic [19:0] I_ADDPC  = 20'hE081F;
    localparam logic [19:0] I_ORRI   = 20'hE3811;
    localparam logic [19:0] I_BADS   = 20'hE1F11;
    localparam logic [19:0] I_NOP    = 20'hEC000;

    initial begin
        reset    = 1'b1;
        Instr    = I_ADD;
        ALUFlags = 4'h0;
        repeat (3) tick();
        #1;
        chk("reset_pcwrite", {3'b0, PCWrite}, 4'd0);
        chk("reset_irwrite", {3'b0, IRWrite}, 4'd0);
        chk("reset_srcb", {2'b0, ALUSrcB}, 4'd2);
        tick();
        reset = 1'b0;

        run_instr(I_ADD, 4'h0, 4);
        chk("add_pcw_fetch", {3'b0, s_pcw[0]}, 4'd1);
        chk("add_pcw_aluwb", {3'b0, s_pcw[3]}, 4'd0);
        chk("add_rw_exec", {3'b0, s_rw[2]}, 4'd0);
        chk("add_rw_aluwb", {3'b0, s_rw[3]}, 4'd1);
        chk("add_aluc", {2'b0, s_aluc[2]}, 4'd0);

        run_instr(I_LDR, 4'h0, 5);
        chk("ldr_adr_memread", {3'b0, s_adr[3]}, 4'd1);
        chk("ldr_res_memwb", {2'b0, s_res[4]}, 4'd1);
        chk("ldr_rw_memwb", {3'b0, s_rw[4]}, 4'd1);

        run_instr(I_SUBS, 4'h0, 4);
        run_instr(I_STREQ, 4'h0, 4);
        chk("streq_z0_mw", {3'b0, s_mw[3]}, 4'd0);
        run_instr(I_SUBS, 4'h4, 4);
        chk("subs_aluc", {2'b0, s_aluc[2]}, 4'd1);
        run_instr(I_STREQ, 4'h0, 4);
        chk("streq_z1_mw", {3'b0, s_mw[3]}, 4'd1);
        run_instr(I_BEQ, 4'h0, 3);
        chk("beq_taken_pcw", {3'b0, s_pcw[2]}, 4'd1);
        run_instr(I_SUBS, 4'h0, 4);
        run_instr(I_BEQ, 4'h0, 3);
        chk("beq_not_taken_pcw", {3'b0, s_pcw[2]}, 4'd0);

        run_instr(I_SUBS, 4'h4, 4);
        run_instr(I_ADDEQS, 4'h0, 4);
        chk("addeqs_rw_aluwb", {3'b0, s_rw[3]}, 4'd1);
        run_instr(I_STREQ, 4'h0, 4);
        chk("after_addeqs_mw", {3'b0, s_mw[3]}, 4'd0);

        run_instr(I_ADDPC, 4'h0, 4);
        chk("addpc_pcw_aluwb", {3'b0, s_pcw[3]}, 4'd1);
        run_instr(I_ORRI, 4'h0, 4);
        chk("orri_aluc", {2'b0, s_aluc[2]}, 4'd3);
        chk("orri_srcb", {2'b0, s_srcb[2]}, 4'd1);
        run_instr(I_BADS, 4'h4, 4);
        chk("bad_cmd_aluc", {2'b0, s_aluc[2]}, 4'd0);
        run_instr(I_STREQ, 4'h0, 4);
        chk("bad_cmd_no_flags_mw", {3'b0, s_mw[3]}, 4'd0);
        run_instr(I_NOP, 4'h0, 2);
        chk("nop_pcw_fetch", {3'b0, s_pcw[0]}, 4'd1);
        chk("nop_pcw_decode", {3'b0, s_pcw[1]}, 4'd0);

        // Reset while a conditional store sits in MEMADR
        run_instr(I_SUBS, 4'h4, 4);
        Instr    = I_STREQ;
        ALUFlags = 4'h0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_pcwrite", {3'b0, PCWrite}, 4'd0);
        chk("midrst_irwrite", {3'b0, IRWrite}, 4'd0);
        chk("midrst_memwrite", {3'b0, MemWrite}, 4'd0);
        chk("midrst_regwrite", {3'b0, RegWrite}, 4'd0);
        chk("midrst_srca", {3'b0, ALUSrcA}, 4'd1);
        $display("reset asserted in MEMADR");
        tick();
        reset = 1'b0;
        run_instr(I_STREQ, 4'h0, 4);
        chk("postrst_pcw_fetch", {3'b0, s_pcw[0]}, 4'd1);
        chk("postrst_flags_cleared_mw", {3'b0, s_mw[3]}, 4'd0);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM datapath: each instruction runs as a sequence of states over a shared memory/ALU datapath. It decodes `Instr[31:12]`, steps a Moore state machine, and holds the NZCV condition flags. It drives every datapath enable and mux select, and gates architectural writes with the condition check.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `Instr`  in  20  instruction bits [31:12] from the instruction register.
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `MemWrite`  out  1  data memory write enable.
- `IRWrite`  out  1  instruction register enable.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUControl`  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- `ALUSrcA`  out  1  0 = A register, 1 = PC.
- `ALUSrcB`  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4.
- `ImmSrc`  out  2  equals `Instr[27:26]`.
- `RegWrite`  out  1  register file write enable.
- `RegSrc`  out  2  bit0 = (Op==10), bit1 = (Op==01).

## Operation
- **Field decode:** `Op = Instr[27:26]`, `Funct = Instr[25:20]`, `Rd = Instr[15:12]`, `Cond = Instr[31:28]`.
- **States and transitions:**
  - FETCH → DECODE.
  - DECODE → MEMADR for Op 01, EXECUTEI for Op 00 with Funct[5]=1, EXECUTER for Op 00 with Funct[5]=0, BRANCH for Op 10, FETCH for Op 11 (NOP).
  - MEMADR → MEMREAD if Funct[0]=1 (load), otherwise MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECUTER and EXECUTEI → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH → FETCH.
- **Per-state outputs (unlisted selects are don't-care, driven 0):**
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch=1.
- **ALU decode:**
  - When ALUOp=1, `Funct[4:1]` selects 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR. Any other value gives ADD with FlagW=00.
  - When ALUOp=0, ALUControl is ADD and FlagW is 00.
  - FlagW[1] (NZ) = Funct[0]. FlagW[0] (CV) = Funct[0] & (ADD|SUB).
- **Condition check:**
  - CondEx is evaluated from `Cond` and the stored Flags using the 14 standard ARM codes. 1110 is always true; 1111 is never true.
  - Flags update at the clock edge only in EXECUTER/EXECUTEI: NZ when FlagW[1]&CondEx, CV when FlagW[0]&CondEx.
  - CondExD is a register loaded with CondEx every cycle. Writeback and branch states use CondExD, so a flag update by the current instruction cannot cancel its own write.
- **Write gating:**
  - PCS = Branch | (RegW & Rd==15).
  - PCWrite = NextPC | (PCS & CondExD).
  - RegWrite = RegW & CondExD.
  - MemWrite = MemW & CondExD.
- A failing condition still walks the full state sequence, but suppresses all writes except the FETCH PC increment.

## Timing
- All outputs are combinational from the state register and CondExD. There are no mid-state output changes other than through `Instr`/Flags.
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, Op 11 NOP 2.
- **Reset:**
  - `reset` high at an edge sets state to FETCH, Flags to 0000 and CondExD to 0.
  - While `reset` is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; all other outputs hold their FETCH values.
  - The first fetch occurs in the first cycle after `reset` deasserts.
- Reset mid-instruction abandons the instruction with no write in the reset cycle.
- Flags written at the EXECUTE edge are visible to the next instruction's condition check in its DECODE/EXECUTE states.

## Structure
- Package `arm_ctrl_pkg`: state enum (10 states), cond-code constants, ALUControl/ResultSrc/ALUSrcB encodings.
- Sub-module `mc_condlogic` holds the Flags registers, the CondEx evaluation, CondExD, and the write-gating equations.
- State register, next-state logic and the output/ALU decode stay in the top module.

## Test plan
- **Register ADD:** Instr=0xE0811 (ADD R1,R1,R2) after reset → states FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 only in ALUWB, ALUControl=00 in EXECUTER, PCWrite=1 only in FETCH.
- **Load:** LDR, Instr=0xE5912 → 5 cycles. AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
- **Conditional store:**
  - Flags Z=0, then STREQ Instr=0x05812 → MEMWRITE reached with MemWrite=0.
  - Repeat with Z=1 → MemWrite=1.
- **Flag-setting compare then branch:** SUBS with ALUFlags=0100 in EXECUTER, then BEQ (Instr=0x0A000) → PCWrite=1 in BRANCH. With ALUFlags=0000, PCWrite=0 in BRANCH.
- **Self-cancelling condition and PC writeback:**
  - ADDEQS R1 with Z=1 producing Z=0 → RegWrite still 1 in ALUWB, because CondExD is used.
  - ADD with Rd=15 → PCWrite=1 in ALUWB.
- **Reset mid-instruction:** assert `reset` in MEMADR → next state FETCH, Flags=0000, no MemWrite/RegWrite pulse, PCWrite=0 and IRWrite=0 while reset is high.
